// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller driving the SRAM BIST port, one operation per cycle,
// with a one-stage read-compare pipeline and abort-on-first-mismatch.
`timescale 1ns/1ps
module sram_bist_ctrl #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 6
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_START,
    input  logic [P_DATA_WIDTH-1:0] A_MEM_DOUT,
    output logic                    A_BIST_EN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic                    A_BIST_CLK,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [2:0]              ELEM_LAST = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [2:0]              elem;
    logic                    phase;
    logic [2:0]              nxt_elem;
    logic [P_ADDR_WIDTH-1:0] nxt_addr;
    logic                    nxt_phase;
    logic                    last_op;
    logic                    cmp_fail;

    logic                    vld_p0;
    logic [P_DATA_WIDTH-1:0] exp_p0;
    logic [P_ADDR_WIDTH-1:0] addr_p0;
    logic [2:0]              elem_p0;

    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic [P_DATA_WIDTH-1:0] wr_pattern(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? {P_DATA_WIDTH{1'b1}} : {P_DATA_WIDTH{1'b0}};
    endfunction

    function automatic logic [P_DATA_WIDTH-1:0] rd_expect(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? {P_DATA_WIDTH{1'b1}} : {P_DATA_WIDTH{1'b0}};
    endfunction

    assign A_BIST_CLK = A_CLK;

    // phase 0 = read, 1 = write; M0 is write-only, M5 read-only
    always_comb begin
        nxt_elem  = elem;
        nxt_addr  = A_BIST_ADDR;
        nxt_phase = 1'b0;
        last_op   = (elem == ELEM_LAST) && (A_BIST_ADDR == ADDR_LAST);
        if (!phase && (elem != ELEM_LAST)) begin
            nxt_phase = 1'b1;
        end else if (elem_down(elem) ? (A_BIST_ADDR == '0) : (A_BIST_ADDR == ADDR_LAST)) begin
            nxt_elem = elem + 3'd1;
            nxt_addr = elem_down(elem + 3'd1) ? ADDR_LAST : '0;
        end else begin
            nxt_phase = (elem == 3'd0);
            nxt_addr  = elem_down(elem) ? A_BIST_ADDR - 1'b1 : A_BIST_ADDR + 1'b1;
        end
    end

    assign cmp_fail = vld_p0 && (A_MEM_DOUT != exp_p0) && ((state == RUN) || (state == DRAIN));

    // Stage p0: expected data, address and element of the read that just ended
    always_ff @(posedge A_CLK) begin
        exp_p0  <= rd_expect(elem);
        addr_p0 <= A_BIST_ADDR;
        elem_p0 <= elem;
    end

    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            state       <= IDLE;
            elem        <= 3'd0;
            phase       <= 1'b0;
            vld_p0      <= 1'b0;
            A_BIST_EN   <= 1'b0;
            A_BIST_ADDR <= '0;
            A_BIST_DIN  <= '0;
            A_BIST_BM   <= '0;
            A_BIST_MEN  <= 1'b0;
            A_BIST_WEN  <= 1'b0;
            A_BIST_REN  <= 1'b0;
            A_BUSY      <= 1'b0;
            A_DONE      <= 1'b0;
            A_FAIL      <= 1'b0;
            A_FAIL_ADDR <= '0;
            A_FAIL_ELEM <= 3'd0;
        end else begin
            vld_p0 <= (state == RUN) && A_BIST_REN;
            case (state)
                IDLE, DONE: begin
                    if (A_START) begin
                        state       <= RUN;
                        elem        <= 3'd0;
                        phase       <= 1'b1;
                        A_BIST_EN   <= 1'b1;
                        A_BIST_ADDR <= '0;
                        A_BIST_DIN  <= wr_pattern(3'd0);
                        A_BIST_BM   <= '1;
                        A_BIST_MEN  <= 1'b1;
                        A_BIST_WEN  <= 1'b1;
                        A_BIST_REN  <= 1'b0;
                        A_BUSY      <= 1'b1;
                        A_DONE      <= 1'b0;
                        A_FAIL      <= 1'b0;
                        A_FAIL_ADDR <= '0;
                        A_FAIL_ELEM <= 3'd0;
                    end
                end
                RUN: begin
                    if (cmp_fail || last_op) begin
                        A_BIST_DIN <= '0;
                        A_BIST_BM  <= '0;
                        A_BIST_MEN <= 1'b0;
                        A_BIST_WEN <= 1'b0;
                        A_BIST_REN <= 1'b0;
                    end
                    if (cmp_fail) begin
                        state       <= DONE;
                        A_BIST_EN   <= 1'b0;
                        A_BUSY      <= 1'b0;
                        A_DONE      <= 1'b1;
                        A_FAIL      <= 1'b1;
                        A_FAIL_ADDR <= addr_p0;
                        A_FAIL_ELEM <= elem_p0;
                    end else if (last_op) begin
                        state <= DRAIN;
                    end else begin
                        elem        <= nxt_elem;
                        phase       <= nxt_phase;
                        A_BIST_ADDR <= nxt_addr;
                        A_BIST_DIN  <= nxt_phase ? wr_pattern(nxt_elem) : '0;
                        A_BIST_BM   <= '1;
                        A_BIST_MEN  <= 1'b1;
                        A_BIST_WEN  <= nxt_phase;
                        A_BIST_REN  <= !nxt_phase;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    A_BIST_EN <= 1'b0;
                    A_BUSY    <= 1'b0;
                    A_DONE    <= 1'b1;
                    if (cmp_fail) begin
                        A_FAIL      <= 1'b1;
                        A_FAIL_ADDR <= addr_p0;
                        A_FAIL_ELEM <= elem_p0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: SRAM model with injectable faults, March C- reference
// built from the element table, randomized memory contents and fault placement.
`timescale 1ns/1ps
module tb_sram_bist_ctrl;
    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int N    = 1 << AW;
    localparam int NOPS = 10 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] mem_dout;
    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_CLK;
    logic          A_BUSY, A_DONE, A_FAIL;
    logic [AW-1:0] A_BIST_ADDR, A_FAIL_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
    logic [2:0]    A_FAIL_ELEM;
    logic [2*AW+2*DW+9:0] all_out;

    sram_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
        .A_CLK(clk), .A_RST(rst), .A_START(start), .A_MEM_DOUT(mem_dout),
        .A_BIST_EN(A_BIST_EN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
        .A_BIST_BM(A_BIST_BM), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
        .A_BIST_REN(A_BIST_REN), .A_BIST_CLK(A_BIST_CLK), .A_BUSY(A_BUSY),
        .A_DONE(A_DONE), .A_FAIL(A_FAIL), .A_FAIL_ADDR(A_FAIL_ADDR), .A_FAIL_ELEM(A_FAIL_ELEM)
    );

    assign all_out = {A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN,
                      A_BIST_REN, A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM};

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_bad   = 0;
    int clk_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(clk) begin
        #1;
        if (A_BIST_CLK !== clk) clk_bad++;
    end

    // fault_mode: 0 healthy, 1 stuck bit on read, 2 write to cp_ag forces cp_vi to the written word
    int            fault_mode, sa_addr, sa_bit, cp_ag, cp_vi;
    logic          sa_val;
    logic [DW-1:0] sram [N];
    logic [DW-1:0] init_mem [N];
    logic          load_mem;

    function automatic logic [DW-1:0] faulty_read(input int a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (fault_mode == 1 && a == sa_addr) r[sa_bit] = sa_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < N; i++) sram[i] <= init_mem[i];
            mem_dout <= '0;
        end else if (A_BIST_MEN) begin
            if (A_BIST_WEN) begin
                sram[A_BIST_ADDR] <= (sram[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
                if (fault_mode == 2 && int'(A_BIST_ADDR) == cp_ag) sram[cp_vi] <= A_BIST_DIN;
            end
            if (A_BIST_REN) mem_dout <= faulty_read(int'(A_BIST_ADDR), sram[A_BIST_ADDR]);
        end
    end

    function automatic logic [63:0] pack_op(input int c, input bit we, input int a, input logic [DW-1:0] d);
        return 64'({8'(c), we, !we, AW'(a), d, {DW{1'b1}}});
    endfunction

    logic [63:0] exp_ops[$];
    int          exp_fail_k, exp_fail_addr, exp_fail_elem;

    // Reference: walk the March C- table over a memory array, first failing read wins
    task automatic build_model();
        int            rd_v [6];
        int            wr_v [6];
        bit            down [6];
        logic [DW-1:0] m [N];
        logic [DW-1:0] d;
        int            k, a;
        rd_v = '{-1, 0, 1, 0, 1, 0};
        wr_v = '{0, 1, 0, 1, 0, -1};
        down = '{0, 0, 0, 1, 1, 0};
        exp_ops.delete();
        exp_fail_k = -1; exp_fail_addr = 0; exp_fail_elem = 0;
        for (int i = 0; i < N; i++) m[i] = init_mem[i];
        k = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = down[e] ? N - 1 - i : i;
                if (rd_v[e] >= 0) begin
                    d = (rd_v[e] != 0) ? {DW{1'b1}} : {DW{1'b0}};
                    exp_ops.push_back(pack_op(k, 1'b0, a, '0));
                    if (exp_fail_k < 0 && faulty_read(a, m[a]) !== d) begin
                        exp_fail_k = k; exp_fail_addr = a; exp_fail_elem = e;
                    end
                    k++;
                end
                if (wr_v[e] >= 0) begin
                    d = (wr_v[e] != 0) ? {DW{1'b1}} : {DW{1'b0}};
                    exp_ops.push_back(pack_op(k, 1'b1, a, d));
                    m[a] = d;
                    if (fault_mode == 2 && a == cp_ag) m[cp_vi] = d;
                    k++;
                end
            end
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) init_mem[i] = DW'($urandom);
        load_mem = 1'b1;
        @(posedge clk);
        #1 load_mem = 1'b0;
    endtask

    task automatic run_test(input bit hold);
        logic [63:0] obs[$];
        int  n_issue, done_c, shape_bad, done_obs, fa, fe;
        bit  fail;
        build_model();
        fail      = (exp_fail_k >= 0);
        n_issue   = fail ? ((exp_fail_k + 2 < NOPS) ? exp_fail_k + 2 : NOPS) : NOPS;
        done_c    = fail ? exp_fail_k + 2 : NOPS + 1;
        fa        = fail ? exp_fail_addr : 0;
        fe        = fail ? exp_fail_elem : 0;
        shape_bad = 0;
        done_obs  = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < NOPS + 8; c++) begin
            #1;
            if (A_BIST_MEN === 1'b1)
                obs.push_back(64'({8'(c), A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM}));
            if ((A_BUSY !== 1'(c < done_c)) || (A_BIST_EN !== A_BUSY) ||
                (A_DONE !== 1'(c >= done_c)) || (c < done_c && A_FAIL !== 1'b0))
                shape_bad++;
            if (A_DONE === 1'b1) begin
                done_obs = c;
                start = 1'b0;
                break;
            end
            if (!hold) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk);
        end
        start = 1'b0;
        chk("done_cycle", 64'(done_obs), 64'(done_c));
        chk("op_count", 64'(obs.size()), 64'(n_issue));
        for (int j = 0; j < n_issue && j < obs.size(); j++)
            chk($sformatf("op%0d", j), obs[j], exp_ops[j]);
        chk("fail_flag", 64'(A_FAIL), 64'(fail));
        chk("fail_addr", 64'(A_FAIL_ADDR), 64'(fa));
        chk("fail_elem", 64'(A_FAIL_ELEM), 64'(fe));
        chk("busy_shape", 64'(shape_bad), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", 64'({A_DONE, A_BUSY, A_BIST_EN, A_BIST_MEN, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, fail, AW'(fa), 3'(fe)}));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_mem = 1'b0;
        fault_mode = 0; sa_addr = 0; sa_bit = 0; sa_val = 1'b0; cp_ag = 1; cp_vi = 0;
        for (int i = 0; i < N; i++) init_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 64'(all_out), 64'd0);
        @(negedge clk) rst = 1'b0;

        load_random();
        run_test(1'b0);

        fault_mode = 1; sa_addr = 2; sa_bit = 3; sa_val = 1'b0;
        load_random();
        run_test(1'b0);
        chk("sa0_addr", 64'(A_FAIL_ADDR), 64'd2);
        chk("sa0_elem", 64'(A_FAIL_ELEM), 64'd2);

        fault_mode = 0;
        load_random();
        run_test(1'b1);

        fault_mode = 2; cp_ag = 1; cp_vi = 0;
        load_random();
        run_test(1'b0);
        chk("cp_addr", 64'(A_FAIL_ADDR), 64'd0);
        chk("cp_elem34", 64'(A_FAIL_ELEM == 3'd3 || A_FAIL_ELEM == 3'd4), 64'd1);

        fault_mode = 0;
        load_random();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (16) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_midrun", 64'(all_out), 64'd0);
        @(negedge clk) rst = 1'b0;
        run_test(1'b0);

        for (int r = 0; r < 6; r++) begin
            fault_mode = int'($urandom_range(0, 2));
            sa_addr    = int'($urandom_range(0, N - 1));
            sa_bit     = int'($urandom_range(0, DW - 1));
            sa_val     = 1'($urandom_range(0, 1));
            cp_ag      = int'($urandom_range(0, N - 1));
            cp_vi      = (cp_ag + int'($urandom_range(1, N - 1))) % N;
            load_random();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_test(1'($urandom_range(0, 1)));
        end

        chk("bist_clk", 64'(clk_bad), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
